// File: rtl/sr_cmd_debounce.sv
// Command front end for an SR flip-flop: synchronizes and debounces raw set/clear lines and emits spaced single-cycle s/r pulses.
// Optional build macro SR_CMD_REDUNDANT_FILTER_EN drops requests that would not change the flip-flop state.
module sr_cmd_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3,
    parameter int PRIO_SET  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s,
    output logic r,
    output logic cmd_busy,
    output logic q_shadow,
    output logic err_both
);

    localparam bit SET_WINS = (PRIO_SET != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Bit 0 carries the set channel, bit 1 the clear channel.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db_level;
    logic [1:0]       db_prev;
    logic [CNT_W-1:0] cnt [2];

    logic   pend_s;
    logic   pend_r;
    state_t state;

    logic [1:0] rise;
    logic       both_rise;
    logic       rise_s;
    logic       rise_r;
    logic       serve_s;
    logic       serve_r;
    logic       go_s;
    logic       go_r;

    // NOTE: every register below is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1   <= {clr_raw, set_raw};
            sync2   <= sync1;
            db_prev <= db_level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db_level[i] <= sync2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A same-edge rise on both channels keeps only the priority winner.
    assign rise      = db_level & ~db_prev;
    assign both_rise = &rise;
    assign rise_s    = rise[0] && (!both_rise || SET_WINS);
    assign rise_r    = rise[1] && (!both_rise || !SET_WINS);

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    always_comb begin
        serve_s = 1'b0;
        serve_r = 1'b0;
        go_s    = 1'b0;
        go_r    = 1'b0;
        if (state == IDLE) begin
            serve_s = pend_s && (SET_WINS || !pend_r);
            serve_r = pend_r && !serve_s;
`ifdef SR_CMD_REDUNDANT_FILTER_EN
            go_s = serve_s && !q_shadow;
            go_r = serve_r && q_shadow;
`else
            go_s = serve_s;
            go_r = serve_r;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s        <= 1'b0;
            r        <= 1'b0;
            q_shadow <= 1'b0;
            err_both <= 1'b0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
        end else begin
            s        <= 1'b0;
            r        <= 1'b0;
            err_both <= both_rise;
            pend_s   <= (pend_s && !serve_s) || rise_s;
            pend_r   <= (pend_r && !serve_r) || rise_r;
            case (state)
                IDLE: begin
                    if (go_s) begin
                        state    <= PULSE_S;
                        s        <= 1'b1;
                        q_shadow <= 1'b1;
                    end else if (go_r) begin
                        state    <= PULSE_R;
                        r        <= 1'b1;
                        q_shadow <= 1'b0;
                    end
                end
                PULSE_S: state <= GAP;
                PULSE_R: state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_busy = (state != IDLE);

endmodule
